// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the data-side load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Unshifted byte-enable mask for an access size.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]              size,
  input  logic [$clog2(DW/8)-1:0] offset,
  input  logic                    sign_ext,
  input  logic [DW-1:0]           wdata,
  input  logic [DW-1:0]           rdata,
  output logic [DW/8-1:0]         sel,
  output logic [DW-1:0]           store_data,
  output logic [DW-1:0]           load_data
);

  localparam int unsigned NB = DW / 8;

  logic [DW-1:0] shifted;
  logic [DW-1:0] mask;
  logic          sign_bit;

  // Byte enables: size mask moved up to the addressed lane.
  assign sel = NB'(size_mask(size)) << offset;

  // Replicate store data across lanes and pull load data down from its lane.
  always_comb begin
    store_data = wdata;
    mask       = '1;
    sign_bit   = 1'b0;
    shifted    = rdata >> {offset, 3'b000};
    case (size_e'(size))
      SZ_B: begin
        store_data = {NB{wdata[7:0]}};
        mask       = DW'(8'hFF);
        sign_bit   = shifted[7];
      end
      SZ_H: begin
        store_data = {(NB/2){wdata[15:0]}};
        mask       = DW'(16'hFFFF);
        sign_bit   = shifted[15];
      end
      SZ_W: begin
        store_data = {(NB/4){wdata[31:0]}};
        mask       = DW'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
      end
      default: ;
    endcase
    load_data = shifted & mask;
    if (sign_ext && sign_bit) load_data = load_data | ~mask;
  end

endmodule

// File: rtl/data_lsu_wb.sv
// Data load/store unit: one pipeline request becomes one classic Wishbone single cycle.
module data_lsu_wb
  import lsu_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_misaligned,
  output logic            rsp_timeout,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);

  state_e          state;
  logic [TW-1:0]   cnt;
  logic            we_q;
  logic            signed_q;
  logic [1:0]      size_q;
  logic [OW-1:0]   off_q;

  logic [OW-1:0]   offset;
  logic            misaligned;
  logic [1:0]      align_size;
  logic [OW-1:0]   align_off;
  logic            align_signed;
  logic [NB-1:0]   lane_sel;
  logic [DW-1:0]   store_data;
  logic [DW-1:0]   load_data;

  assign offset = req_addr[OW-1:0];

  // Alignment check on the incoming request; dword is illegal on a 32-bit bus.
  always_comb begin
    misaligned = 1'b0;
    case (size_e'(req_size))
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = |offset[1:0];
      SZ_D:    misaligned = (DW == 32) || (|offset);
      default: misaligned = 1'b0;
    endcase
  end

  // Lane logic sees the live request while idle and the held request afterwards.
  always_comb begin
    align_size   = size_q;
    align_off    = off_q;
    align_signed = signed_q;
    if (state == ST_IDLE) begin
      align_size   = req_size;
      align_off    = offset;
      align_signed = req_signed;
    end
  end

  lsu_lane_align #(.DW(DW)) u_lane_align (
    .size       (align_size),
    .offset     (align_off),
    .sign_ext   (align_signed),
    .wdata      (req_wdata),
    .rdata      (wb_dat_i),
    .sel        (lane_sel),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // Request/bus/response sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      rsp_misaligned <= 1'b0;
      rsp_timeout    <= 1'b0;
      wb_adr_o       <= '0;
      wb_dat_o       <= '0;
      wb_sel_o       <= '0;
      wb_we_o        <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      we_q           <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'd0;
      off_q          <= '0;
    end else begin
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      rsp_misaligned <= 1'b0;
      rsp_timeout    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size;
            off_q     <= offset;
            if (misaligned) begin
              state          <= ST_RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
            end else begin
              state    <= ST_BUS;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= req_we;
              wb_adr_o <= {req_addr[AW-1:OW], OW'(0)};
              wb_sel_o <= lane_sel;
              wb_dat_o <= store_data;
            end
          end
        end
        ST_BUS: begin
          cnt <= cnt + TW'(1);
          if (wb_err_i || wb_ack_i || (cnt == TW'(TIMEOUT - 1))) begin
            state     <= ST_RESP;
            cnt       <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_valid <= 1'b1;
            if (wb_err_i) begin
              rsp_err <= 1'b1;
            end else if (wb_ack_i) begin
              if (!we_q) rsp_rdata <= load_data;
            end else begin
              rsp_timeout <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_lsu_wb.sv
// Self-checking bench: a 32-bit unit (TIMEOUT=8) and a 64-bit unit (TIMEOUT=16).
module tb_data_lsu_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, b_rst, a_req_valid, b_req_valid;
  logic        req_we, req_signed, wb_ack_i, wb_err_i;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, wb_dat_i;

  logic        a_ready, a_rv, a_err, a_mis, a_to, a_we, a_cyc, a_stb;
  logic [31:0] a_rdata, a_adr, a_dat;
  logic [3:0]  a_sel;
  logic        b_ready, b_rv, b_err, b_mis, b_to, b_we, b_cyc, b_stb;
  logic [63:0] b_rdata, b_dat;
  logic [31:0] b_adr;
  logic [7:0]  b_sel;

  data_lsu_wb #(.DW(32), .AW(32), .TIMEOUT(8)) u_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err),
    .rsp_misaligned(a_mis), .rsp_timeout(a_to),
    .wb_adr_o(a_adr), .wb_dat_o(a_dat), .wb_sel_o(a_sel), .wb_we_o(a_we),
    .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_dat_i(wb_dat_i[31:0]),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  data_lsu_wb #(.DW(64), .AW(32), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .rsp_misaligned(b_mis), .rsp_timeout(b_to),
    .wb_adr_o(b_adr), .wb_dat_o(b_dat), .wb_sel_o(b_sel), .wb_we_o(b_we),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Selected unit's outputs, widened to 64-bit lanes.
  logic        wide;
  logic        m_ready, m_rv, m_err, m_mis, m_to, m_we, m_cyc, m_stb;
  logic [63:0] m_rdata, m_dat;
  logic [31:0] m_adr;
  logic [7:0]  m_sel;
  always_comb begin
    if (wide) begin
      {m_ready, m_rv, m_err, m_mis, m_to, m_we, m_cyc, m_stb} =
        {b_ready, b_rv, b_err, b_mis, b_to, b_we, b_cyc, b_stb};
      m_rdata = b_rdata; m_dat = b_dat; m_adr = b_adr; m_sel = b_sel;
    end else begin
      {m_ready, m_rv, m_err, m_mis, m_to, m_we, m_cyc, m_stb} =
        {a_ready, a_rv, a_err, a_mis, a_to, a_we, a_cyc, a_stb};
      m_rdata = {32'd0, a_rdata}; m_dat = {32'd0, a_dat}; m_adr = a_adr; m_sel = {4'd0, a_sel};
    end
  end

  int checks = 0;
  int errors = 0;

  // Observations of the last transaction.
  int          o_lat, o_ncyc;
  bit          o_stray;
  logic [2:0]  o_flags;   // {err, misaligned, timeout}
  logic [63:0] o_rdata, o_dat;
  logic [31:0] o_adr;
  logic [7:0]  o_sel;
  logic        o_we;

  // Reference model: spec rules in plain arithmetic.
  function automatic bit ref_misal(input logic [1:0] sz, input logic [31:0] ad, input int nb);
    int n = 1 << sz;
    int off = int'(ad[2:0]) % nb;
    return (n > nb) || ((off % n) != 0);
  endfunction

  function automatic logic [7:0] ref_sel(input logic [1:0] sz, input logic [31:0] ad, input int nb);
    int n = 1 << sz;
    int off = int'(ad[2:0]) % nb;
    return 8'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [63:0] ref_dat(input logic [1:0] sz, input logic [63:0] wd, input int nb);
    logic [63:0] r;
    int n = 1 << sz;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rdata(input logic [1:0] sz, input logic sg,
                                            input logic [31:0] ad, input logic [63:0] bd, input int nb);
    int n = 1 << sz;
    int off = int'(ad[2:0]) % nb;
    logic [63:0] mask, v;
    mask = (n == 8) ? '1 : ((64'd1 << (8*n)) - 64'd1);
    v = (bd >> (8*off)) & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // Issue one request and play the slave. mode: 0 ack, 1 err, 2 ack+err, 3 silent.
  task automatic run_txn(input bit w, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [63:0] wd, input logic [63:0] bd,
                         input int mode, input int waits);
    int guard;
    wide = w;
    o_lat = -1; o_ncyc = 0; o_stray = 1'b0; o_flags = 3'b000; o_rdata = '0;
    o_dat = '0; o_adr = '0; o_sel = '0; o_we = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!m_ready && guard < 20) begin @(negedge clk); guard++; end
    req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd; wb_dat_i = bd;
    if (w) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (m_ready) o_stray = 1'b1;
      if (m_rv) begin
        o_lat = c; o_flags = {m_err, m_mis, m_to}; o_rdata = m_rdata;
        if (m_cyc || m_stb) o_stray = 1'b1;
        break;
      end
      if (m_err || m_mis || m_to || (m_rdata != 64'd0)) o_stray = 1'b1;
      if (m_cyc !== m_stb) o_stray = 1'b1;
      if (m_cyc) begin
        o_ncyc++;
        if (o_ncyc == 1) begin
          o_adr = m_adr; o_sel = m_sel; o_dat = m_dat; o_we = m_we;
        end else if (o_adr !== m_adr || o_sel !== m_sel || o_dat !== m_dat || o_we !== m_we) begin
          o_stray = 1'b1;
        end
        if (o_ncyc == waits + 1) begin
          wb_ack_i = (mode == 0 || mode == 2);
          wb_err_i = (mode == 1 || mode == 2);
        end
      end
      @(negedge clk);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b expected 11", {a_ready, b_ready});
    end
    checks++;
    if ({a_rv, a_err, a_mis, a_to, a_we, a_cyc, a_stb, b_rv, b_err, b_mis, b_to, b_we, b_cyc, b_stb} !== 14'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {a_rv, a_err, a_mis, a_to, a_we, a_cyc, a_stb, b_rv, b_err, b_mis, b_to, b_we, b_cyc, b_stb});
    end
    checks++;
    if ({a_rdata, a_adr, a_dat, a_sel, b_rdata, b_adr, b_dat, b_sel} !== '0) begin
      errors++; $display("FAIL reset_data: got adr %h/%h sel %h/%h expected 0", a_adr, b_adr, a_sel, b_sel);
    end
  endtask

  task automatic test_word_load();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 64'd0, 64'hDEADBEEF, 0, 2);
    checks++;
    if (o_lat !== 4 || o_ncyc !== 3) begin
      errors++; $display("FAIL word_load_timing: got lat %0d cyc %0d expected 4 3", o_lat, o_ncyc);
    end
    checks++;
    if (o_sel !== 8'h0F || o_adr !== 32'h100 || o_we !== 1'b0) begin
      errors++; $display("FAIL word_load_bus: got sel %h adr %h we %b expected 0f 100 0", o_sel, o_adr, o_we);
    end
    checks++;
    if (o_rdata !== 64'hDEADBEEF || o_flags !== 3'b000 || o_stray) begin
      errors++; $display("FAIL word_load_rsp: got %h flags %b stray %b expected deadbeef 000 0", o_rdata, o_flags, o_stray);
    end
  endtask

  task automatic test_byte_load();
    run_txn(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 64'd0, 64'h80123456, 0, 0);
    checks++;
    if (o_sel !== 8'h08 || o_rdata !== 64'hFFFFFF80 || o_lat !== 2) begin
      errors++; $display("FAIL byte_signed: got sel %h data %h lat %0d expected 08 ffffff80 2", o_sel, o_rdata, o_lat);
    end
    run_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 64'd0, 64'h80123456, 0, 0);
    checks++;
    if (o_sel !== 8'h08 || o_rdata !== 64'h80 || o_adr !== 32'h100) begin
      errors++; $display("FAIL byte_unsigned: got sel %h data %h adr %h expected 08 80 100", o_sel, o_rdata, o_adr);
    end
  endtask

  task automatic test_half_store();
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 64'h1234ABCD, 64'hFFFF_FFFF, 0, 1);
    checks++;
    if (o_sel !== 8'h0C || o_dat !== 64'hABCDABCD || o_we !== 1'b1) begin
      errors++; $display("FAIL half_store_bus: got sel %h dat %h we %b expected 0c abcdabcd 1", o_sel, o_dat, o_we);
    end
    checks++;
    if (o_flags !== 3'b000 || o_rdata !== 64'd0 || o_lat !== 3 || o_stray) begin
      errors++; $display("FAIL half_store_rsp: got flags %b data %h lat %0d expected 000 0 3", o_flags, o_rdata, o_lat);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h101, 64'd0, 64'h55, 0, 0);
    checks++;
    if (o_lat !== 1 || o_ncyc !== 0 || o_flags !== 3'b010 || o_rdata !== 64'd0) begin
      errors++; $display("FAIL misaligned_word: got lat %0d cyc %0d flags %b expected 1 0 010", o_lat, o_ncyc, o_flags);
    end
    run_txn(1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 64'd0, 64'h55, 0, 0);
    checks++;
    if (o_lat !== 1 || o_ncyc !== 0 || o_flags !== 3'b010) begin
      errors++; $display("FAIL illegal_dword32: got lat %0d cyc %0d flags %b expected 1 0 010", o_lat, o_ncyc, o_flags);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 64'd0, 64'h0, 3, 0);
    checks++;
    if (o_ncyc !== 8 || o_lat !== 9 || o_flags !== 3'b001 || o_rdata !== 64'd0) begin
      errors++; $display("FAIL timeout: got cyc %0d lat %0d flags %b expected 8 9 001", o_ncyc, o_lat, o_flags);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_ready: got %b expected 1", a_ready);
    end
  endtask

  task automatic test_ack_err();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 64'd0, 64'h12345678, 2, 1);
    checks++;
    if (o_flags !== 3'b100 || o_rdata !== 64'd0 || o_lat !== 3) begin
      errors++; $display("FAIL ack_err: got flags %b data %h lat %0d expected 100 0 3", o_flags, o_rdata, o_lat);
    end
  endtask

  task automatic test_spurious();
    bit seen;
    seen = 1'b0;
    wide = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      wb_ack_i = 1'b1; wb_err_i = (c % 2) == 1;
      @(negedge clk);
      if (a_rv || a_cyc || b_rv || b_cyc || !a_ready) seen = 1'b1;
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL spurious_ack: got activity %b expected 0", seen);
    end
  endtask

  task automatic test_dw64();
    run_txn(1'b1, 1'b0, 2'd3, 1'b0, 32'h208, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0);
    checks++;
    if (o_sel !== 8'hFF || o_adr !== 32'h208 || o_rdata !== 64'h0123_4567_89AB_CDEF || o_lat !== 2) begin
      errors++; $display("FAIL dword_load: got sel %h adr %h data %h lat %0d expected ff 208 0123456789abcdef 2",
                         o_sel, o_adr, o_rdata, o_lat);
    end
    run_txn(1'b1, 1'b0, 2'd1, 1'b1, 32'h20E, 64'd0, 64'h8765_0000_0000_0000, 0, 0);
    checks++;
    if (o_sel !== 8'hC0 || o_adr !== 32'h208 || o_rdata !== 64'hFFFF_FFFF_FFFF_8765) begin
      errors++; $display("FAIL half64_signed: got sel %h adr %h data %h expected c0 208 ffffffffffff8765",
                         o_sel, o_adr, o_rdata);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit seen;
    seen = 1'b0;
    wide = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 32'h210;
    b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++;
    if (b_cyc !== 1'b1) begin
      errors++; $display("FAIL rst_mid_start: got cyc %b expected 1", b_cyc);
    end
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    checks++;
    if ({b_cyc, b_stb, b_rv} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_drop: got cyc/stb/rv %b expected 000", {b_cyc, b_stb, b_rv});
    end
    for (int c = 0; c < 6; c++) begin
      wb_ack_i = 1'b1;
      @(negedge clk);
      if (b_rv || b_cyc) seen = 1'b1;
    end
    wb_ack_i = 1'b0;
    checks++;
    if (seen !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_after: got activity %b ready %b expected 0 1", seen, b_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          w, we, sg, mis;
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [63:0] wd, bd, e_rdata;
      logic [2:0]  e_flags;
      int          mode, waits, r, nb, tmo, e_lat, e_ncyc;
      w = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); ad = $urandom;
      if ($urandom_range(0, 2) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      wd = {$urandom, $urandom}; bd = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
      waits = $urandom_range(0, 3);
      nb = w ? 8 : 4; tmo = w ? 16 : 8;
      run_txn(w, we, sz, sg, ad, wd, bd, mode, waits);
      mis = ref_misal(sz, ad, nb);
      e_rdata = '0;
      if (mis) begin
        e_lat = 1; e_ncyc = 0; e_flags = 3'b010;
      end else if (mode == 3) begin
        e_lat = tmo + 1; e_ncyc = tmo; e_flags = 3'b001;
      end else begin
        e_lat = waits + 2; e_ncyc = waits + 1;
        e_flags = (mode == 0) ? 3'b000 : 3'b100;
        if (mode == 0 && !we) e_rdata = ref_rdata(sz, sg, ad, bd, nb);
      end
      checks++;
      if (o_lat !== e_lat || o_ncyc !== e_ncyc || o_stray) begin
        errors++; $display("FAIL rand%0d_timing: got lat %0d cyc %0d stray %b expected %0d %0d 0",
                           i, o_lat, o_ncyc, o_stray, e_lat, e_ncyc);
      end
      checks++;
      if (o_flags !== e_flags || o_rdata !== e_rdata) begin
        errors++; $display("FAIL rand%0d_rsp: got flags %b data %h expected %b %h", i, o_flags, o_rdata, e_flags, e_rdata);
      end
      if (!mis) begin
        checks++;
        if (o_sel !== ref_sel(sz, ad, nb) || o_adr !== (ad & ~32'(nb - 1)) || o_we !== we ||
            (we && o_dat !== ref_dat(sz, wd, nb))) begin
          errors++; $display("FAIL rand%0d_bus: got sel %h adr %h we %b dat %h expected %h %h %b %h", i,
                             o_sel, o_adr, o_we, o_dat, ref_sel(sz, ad, nb), ad & ~32'(nb - 1), we, ref_dat(sz, wd, nb));
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    wide = 1'b0;
    a_rst = 1'b1; b_rst = 1'b1; a_req_valid = 1'b0; b_req_valid = 1'b0;
    req_we = 1'b0; req_signed = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_ack_err();
    test_spurious();
    test_dw64();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_lsu_wb.md
Name: data_lsu_wb

Overview:
Parametrised data-side load/store unit that turns single pipeline memory requests into classic Wishbone single-read/write cycles. It generalises the fetch-only load/store unit in four ways: configurable data and address width, byte/half/word/dword sizes with lane steering and sign extension, misalignment detection, and a parametrised bus timeout that recovers to idle instead of hanging. It sits between the execute stage and the data-memory Wishbone port.

Parameters:
DW, 32, data bus width; legal values 32 or 64.
AW, 32, address width.
TIMEOUT, 1023, bus cycles with cyc/stb high and no ack/err before abort; must be >= 1.
TW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
req_signed  in  1  sign-extend load data.
req_addr  in  AW  byte address.
req_wdata  in  DW  store data, right-aligned.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  DW  load data, extended; 0 for stores and faults.
rsp_err  out  1  bus error (wb_err_i).
rsp_misaligned  out  1  misaligned or illegal size; no bus cycle issued.
rsp_timeout  out  1  no ack/err within TIMEOUT cycles.
wb_adr_o  out  AW  address, low log2(DW/8) bits forced to 0.
wb_dat_o  out  DW  lane-steered store data.
wb_sel_o  out  DW/8  byte enables.
wb_we_o  out  1  write enable.
wb_cyc_o  out  1  cycle.
wb_stb_o  out  1  strobe.
wb_dat_i  in  DW  read data.
wb_ack_i  in  1  ack.
wb_err_i  in  1  error.

Behaviour:
- Reset values: state IDLE; req_ready 1; rsp_valid, rsp_err, rsp_misaligned, rsp_timeout, wb_cyc_o, wb_stb_o, wb_we_o 0; rsp_rdata, wb_adr_o, wb_dat_o 0; wb_sel_o 0; timeout counter 0.
- States: IDLE, BUS, RESP. req_ready = (state == IDLE). Handshake: accept on req_valid && req_ready at a rising edge.
- Offset = req_addr[log2(DW/8)-1:0].
  - Misaligned when: half with offset[0] != 0; word with offset[1:0] != 0; dword with offset != 0; size 3 with DW = 32 (illegal).
- Misaligned accept: IDLE -> RESP. The next cycle has rsp_valid = 1 with rsp_misaligned = 1 and no Wishbone activity. Latency is 1.
- Aligned accept: IDLE -> BUS. The next cycle has:
  - wb_cyc_o = wb_stb_o = 1; wb_we_o = req_we; wb_adr_o = aligned address.
  - wb_sel_o: size mask shifted by offset (byte 1, half 3, word 0xF, dword 0xFF).
  - wb_dat_o: req_wdata low bytes replicated across all lanes.
  - Request fields are registered, so the bus is stable while in BUS.
- BUS: the counter increments every cycle. At the edge where it is sampled:
  - wb_err_i: drop cyc/stb; rsp_valid next cycle with rsp_err = 1.
  - Else wb_ack_i: drop cyc/stb; rsp_valid next cycle. For a load, capture wb_dat_i, select bytes at offset, then zero- or sign-extend to DW.
  - Else counter == TIMEOUT-1: drop cyc/stb; rsp_valid with rsp_timeout = 1.
  - Priority: err > ack > timeout.
- Minimum aligned latency (accept to rsp_valid) is 2 cycles with a zero-wait slave.
- RESP: rsp_valid high exactly one cycle, then IDLE. req_ready rises in the cycle after rsp_valid. Counter cleared on leaving BUS.
- rsp_* flags and rsp_rdata are meaningful only while rsp_valid = 1 and are 0 otherwise. Flags are mutually exclusive.
- ack/err seen in IDLE or RESP are ignored.
- rst mid-transaction: cyc/stb low at the next edge, no response generated, pending request discarded.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - State encoding.
  - Function size_mask(size) returning the unshifted byte mask.
- One combinational sub-module, lsu_lane_align: from size/offset/signed it produces wb_sel_o, the replicated store data and the extended load data. Parametrised by DW.

Test Plan:
- DW=32, word load at 0x100, slave acks after 2 waits with 0xDEADBEEF -> wb_sel_o = 0xF, wb_adr_o = 0x100, rsp_rdata = 0xDEADBEEF, 4 cycles accept-to-rsp.
- Signed byte load at 0x103, bus data 0x80xxxxxx -> wb_sel_o = 0x8, rsp_rdata = 0xFFFFFF80. Unsigned -> 0x00000080.
- Half store 0xABCD at 0x102 -> wb_sel_o = 0xC, wb_dat_o = 0xABCDABCD, wb_we_o = 1, rsp_valid with all flags 0.
- Word load at 0x101; separately, size 3 with DW=32 -> no cyc, rsp_misaligned = 1 one cycle after accept.
- TIMEOUT=8, silent slave -> cyc/stb high exactly 8 cycles, then rsp_timeout = 1 and req_ready back. Ack and err asserted together -> rsp_err only.
- DW=64 dword load at 0x208 -> wb_sel_o = 0xFF. Then assert rst during BUS -> cyc/stb low next edge, no rsp_valid.
